// File: rtl/seg7_to_hex_encoder.sv
// Reads back a 7-segment bus, debounces each glyph, and encodes it to a hex nibble.
// Each word is handed downstream over valid/ready, with one skid slot behind the output word.
module seg7_to_hex_encoder #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter bit          ACTIVE_LOW    = 1'b1
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [6:0] SEG_IN,
  input  logic       out_ready,
  input  logic       clr_overrun,
  output logic       out_valid,
  output logic [3:0] out_nibble,
  output logic       out_invalid,
  output logic       out_blank,
  output logic       overrun
);
  localparam int unsigned SegW  = 7;
  localparam int unsigned CntW  = 8;
  localparam int unsigned WordW = 6;
  localparam logic [SegW-1:0] BlankGlyph = ACTIVE_LOW ? 7'h7F : 7'h00;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  logic [SegW-1:0]  s1_q, s2_q;
  logic [SegW-1:0]  cand_q, cand_d, last_q, last_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             emitted_q, emitted_d;
  logic             ev_c, hs_c, ovr_set_c;
  logic [SegW-1:0]  norm_c;
  logic [3:0]       nib_c;
  logic             inv_c, blank_c;
  logic [WordW-1:0] new_word_c;

  state_e           state_q;
  logic [WordW-1:0] out_word_q, skid_q;
  logic             skid_v_q, overrun_q;

  // Two-flop synchroniser for the asynchronous segment bus
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      s1_q <= BlankGlyph;
      s2_q <= BlankGlyph;
    end else begin
      s1_q <= SEG_IN;
      s2_q <= s1_q;
    end
  end

  assign ev_c = (cnt_q == CntW'(STABLE_CYCLES)) && !emitted_q && (cand_q != last_q);

  // Stability tracker: restart on any change, saturate at the threshold
  always_comb begin
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    emitted_d = emitted_q;
    last_d    = last_q;
    if (ev_c) begin
      emitted_d = 1'b1;
      last_d    = cand_q;
    end
    if (s2_q != cand_q) begin
      cand_d    = s2_q;
      cnt_d     = CntW'(1);
      emitted_d = 1'b0;
    end else if (cnt_q != CntW'(STABLE_CYCLES)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      cand_q    <= BlankGlyph;
      last_q    <= BlankGlyph;
      cnt_q     <= '0;
      emitted_q <= 1'b0;
    end else begin
      cand_q    <= cand_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      emitted_q <= emitted_d;
    end
  end

  // Glyph lookup works on the active-low form
  assign norm_c = ACTIVE_LOW ? cand_q : ~cand_q;

  always_comb begin
    nib_c   = 4'h0;
    inv_c   = 1'b0;
    blank_c = 1'b0;
    case (norm_c)
      7'h40:   nib_c = 4'h0;
      7'h79:   nib_c = 4'h1;
      7'h24:   nib_c = 4'h2;
      7'h30:   nib_c = 4'h3;
      7'h19:   nib_c = 4'h4;
      7'h12:   nib_c = 4'h5;
      7'h02:   nib_c = 4'h6;
      7'h78:   nib_c = 4'h7;
      7'h00:   nib_c = 4'h8;
      7'h10:   nib_c = 4'h9;
      7'h08:   nib_c = 4'hA;
      7'h03:   nib_c = 4'hB;
      7'h46:   nib_c = 4'hC;
      7'h21:   nib_c = 4'hD;
      7'h06:   nib_c = 4'hE;
      7'h0E:   nib_c = 4'hF;
      7'h7F:   blank_c = 1'b1;
      default: inv_c = 1'b1;
    endcase
  end

  assign new_word_c = {nib_c, inv_c, blank_c};
  assign hs_c       = (state_q == FULL) && out_ready;
  assign ovr_set_c  = (state_q == FULL) && !hs_c && ev_c && skid_v_q;

  // Output word plus skid slot; the newest word replaces a full skid slot
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q    <= EMPTY;
      out_word_q <= '0;
      skid_q     <= '0;
      skid_v_q   <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      if (state_q == EMPTY) begin
        if (ev_c) begin
          out_word_q <= new_word_c;
          state_q    <= FULL;
        end
      end else if (hs_c) begin
        if (ev_c) begin
          if (skid_v_q) begin
            out_word_q <= skid_q;
            skid_q     <= new_word_c;
          end else begin
            out_word_q <= new_word_c;
          end
        end else if (skid_v_q) begin
          out_word_q <= skid_q;
          skid_v_q   <= 1'b0;
        end else begin
          state_q <= EMPTY;
        end
      end else if (ev_c) begin
        skid_q   <= new_word_c;
        skid_v_q <= 1'b1;
      end
      if (clr_overrun) begin
        overrun_q <= 1'b0;
      end else if (ovr_set_c) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign out_valid                            = (state_q == FULL);
  assign {out_nibble, out_invalid, out_blank} = out_word_q;
  assign overrun                              = overrun_q;

endmodule

// File: tb/tb_seg7_to_hex_encoder.sv
// Bench for seg7_to_hex_encoder: a run-length and queue model is checked every cycle,
// alongside directed scenarios whose expected words are written out by hand.
module tb_seg7_to_hex_encoder;
  localparam int unsigned STABLE = 4;
  localparam logic [6:0]  BLANK  = 7'h7F;

  logic       clk;
  logic       resetn;
  logic [6:0] seg_in;
  logic       out_ready;
  logic       clr_overrun;
  logic       out_valid;
  logic [3:0] out_nibble;
  logic       out_invalid;
  logic       out_blank;
  logic       overrun;

  seg7_to_hex_encoder #(.STABLE_CYCLES(STABLE), .ACTIVE_LOW(1'b1)) dut (
    .CLOCK_50   (clk),
    .resetn     (resetn),
    .SEG_IN     (seg_in),
    .out_ready  (out_ready),
    .clr_overrun(clr_overrun),
    .out_valid  (out_valid),
    .out_nibble (out_nibble),
    .out_invalid(out_invalid),
    .out_blank  (out_blank),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Active-low glyphs for 0..F, bits g..a
  logic [6:0] glyph_tab [16];
  initial begin
    glyph_tab[0]  = 7'b1000000; glyph_tab[1]  = 7'b1111001;
    glyph_tab[2]  = 7'b0100100; glyph_tab[3]  = 7'b0110000;
    glyph_tab[4]  = 7'b0011001; glyph_tab[5]  = 7'b0010010;
    glyph_tab[6]  = 7'b0000010; glyph_tab[7]  = 7'b1111000;
    glyph_tab[8]  = 7'b0000000; glyph_tab[9]  = 7'b0010000;
    glyph_tab[10] = 7'b0001000; glyph_tab[11] = 7'b0000011;
    glyph_tab[12] = 7'b1000110; glyph_tab[13] = 7'b0100001;
    glyph_tab[14] = 7'b0000110; glyph_tab[15] = 7'b0001110;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Word layout {nibble, invalid, blank}
  function automatic logic [5:0] enc(input logic [6:0] g);
    if (g == BLANK) return 6'b000001;
    for (int i = 0; i < 16; i++)
      if (glyph_tab[i] == g) return {4'(i), 2'b00};
    return 6'b000010;
  endfunction

  // Model: a glyph is emitted once per run, when its run of samples (two-sample delayed)
  // first reaches STABLE and it differs from the last emitted glyph; the output side is a
  // two-deep queue in which a new word overwrites the tail if the queue is full.
  logic [5:0] mq [$];
  logic [6:0] m_d1, m_d2, m_glyph, m_last;
  int         m_run;
  logic       m_ovr;

  task automatic m_reset();
    mq.delete();
    m_d1 = BLANK; m_d2 = BLANK; m_glyph = BLANK; m_last = BLANK;
    m_run = 0; m_ovr = 1'b0;
  endtask

  task automatic m_step();
    logic ev, set_ovr;
    logic [6:0] c;
    ev = (m_run == int'(STABLE)) && (m_glyph != m_last);
    set_ovr = 1'b0;
    if (mq.size() != 0 && out_ready) void'(mq.pop_front());
    if (ev) begin
      m_last = m_glyph;
      if (mq.size() == 2) begin
        mq[1] = enc(m_glyph);
        set_ovr = 1'b1;
      end else begin
        mq.push_back(enc(m_glyph));
      end
    end
    if (clr_overrun) m_ovr = 1'b0;
    else if (set_ovr) m_ovr = 1'b1;
    c = m_d2; m_d2 = m_d1; m_d1 = seg_in;
    if (c == m_glyph) m_run++;
    else begin m_glyph = c; m_run = 1; end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) m_reset();
      else m_step();
    end
  end

  // Per-cycle comparison against the model, just after the active edge
  initial forever begin
    @(posedge clk);
    #1;
    if (resetn === 1'b1) begin
      chk("valid", 32'(out_valid), 32'(mq.size() != 0));
      if (mq.size() != 0 && out_valid === 1'b1)
        chk("word", 32'({out_nibble, out_invalid, out_blank}), 32'(mq[0]));
      chk("overrun", 32'(overrun), 32'(m_ovr));
    end
  end

  // Record accepted words mid-cycle
  logic [5:0] got [$];
  initial forever begin
    @(negedge clk);
    if (resetn === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1)
      got.push_back({out_nibble, out_invalid, out_blank});
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #3; end
  endtask

  // From a drive point right after reset release: check the rise at edge STABLE+3
  task automatic latency_check(input string tag, input logic [3:0] nib);
    for (int e = 1; e <= 7; e++) begin
      @(posedge clk); #1;
      if (e == 6) chk({tag, "_e6_valid"}, 32'(out_valid), 32'd0);
      if (e == 7) begin
        chk({tag, "_e7_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_e7_word"}, 32'({out_nibble, out_invalid, out_blank}), 32'({nib, 2'b00}));
      end
    end
    #2;
  endtask

  initial begin
    logic found;
    resetn = 1'b0; seg_in = 7'b1000000; out_ready = 1'b1; clr_overrun = 1'b0;
    cyc(2);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_word", 32'({out_nibble, out_invalid, out_blank}), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);

    // T1: glyph 0 appears at edge 7 for one cycle
    resetn = 1'b1;
    latency_check("t1", 4'h0);
    @(posedge clk); #1;
    chk("t1_e8_valid", 32'(out_valid), 32'd0);
    #2;

    // T2: short glitch of 5 is dropped, 0 not re-emitted
    seg_in = 7'b0010010; cyc(3);
    seg_in = 7'b1000000; cyc(20);
    chk("t2_words", 32'(got.size()), 32'd1);

    // T3: all 16 glyphs in order after a silent blank reset
    seg_in = BLANK; resetn = 1'b0; cyc(2); resetn = 1'b1; cyc(10);
    got.delete();
    for (int i = 0; i < 16; i++) begin seg_in = glyph_tab[i]; cyc(10); end
    cyc(5);
    chk("t3_count", 32'(got.size()), 32'd16);
    for (int i = 0; i < 16 && i < got.size(); i++)
      chk("t3_word", 32'(got[i]), 32'({4'(i), 2'b00}));

    // T4: invalid glyph then blank
    got.delete();
    seg_in = 7'b1010101; cyc(10);
    seg_in = BLANK;      cyc(10);
    chk("t4_count", 32'(got.size()), 32'd2);
    if (got.size() == 2) begin
      chk("t4_invalid", 32'(got[0]), 32'h02);
      chk("t4_blank", 32'(got[1]), 32'h01);
    end

    // T5: backpressure, skid overwrite and overrun
    got.delete(); out_ready = 1'b0;
    seg_in = 7'b1111001; cyc(10);
    seg_in = 7'b0100100; cyc(10);
    seg_in = 7'b0110000; cyc(10);
    chk("t5_hold_valid", 32'(out_valid), 32'd1);
    chk("t5_hold_nibble", 32'(out_nibble), 32'h1);
    chk("t5_overrun_set", 32'(overrun), 32'd1);
    out_ready = 1'b1; cyc(5);
    chk("t5_count", 32'(got.size()), 32'd2);
    if (got.size() == 2) begin
      chk("t5_first", 32'(got[0]), 32'h04);
      chk("t5_second", 32'(got[1]), 32'h0C);
    end
    chk("t5_overrun_sticky", 32'(overrun), 32'd1);
    clr_overrun = 1'b1; cyc(1); clr_overrun = 1'b0;
    chk("t5_overrun_clr", 32'(overrun), 32'd0);

    // T6: async reset drops a held word; glyph 7 returns at edge 7
    out_ready = 1'b0; seg_in = 7'b1111000;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin cyc(1); if (out_valid) found = 1'b1; end
    chk("t6_wait_valid", 32'(found), 32'd1);
    chk("t6_full_nibble", 32'(out_nibble), 32'h7);
    resetn = 1'b0; #1;
    chk("t6_async_drop", 32'(out_valid), 32'd0);
    cyc(2);
    out_ready = 1'b1; resetn = 1'b1;
    latency_check("t6", 4'h7);
    cyc(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
